// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Accepts load / ALU-op commands, drives an external combinational ALU for
//   one cycle per op, accumulates the result and presents it as a response
//   held until the consumer takes it.
//
// Parameters
//   n                 operand / accumulator width
//
// Ports
//   clk               clock, all state changes on the rising edge
//   rst_n             synchronous active-low reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_load          1 = load cmd_opnd into the accumulator, 0 = ALU op
//   cmd_mode          ALU mode, passed through undecoded
//   cmd_opnd          ALU B operand or load value
//   alu_a/b/mode      drive the downstream ALU (held outside EXEC)
//   alu_result        combinational ALU result
//   alu_carry_borrow  combinational ALU carry / borrow
//   rsp_valid/ready   response handshake
//   rsp_result        accumulator
//   rsp_carry         carry / borrow flag
//   rsp_zero          accumulator == 0
//   op_count          completed ALU ops, saturating at 255
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_load,
   input  logic [2:0]   cmd_mode,
   input  logic [n-1:0] cmd_opnd,
   output logic [n-1:0] alu_a,
   output logic [n-1:0] alu_b,
   output logic [2:0]   alu_mode,
   input  logic [n-1:0] alu_result,
   input  logic         alu_carry_borrow,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [n-1:0] rsp_result,
   output logic         rsp_carry,
   output logic         rsp_zero,
   output logic [7:0]   op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e       state_q, state_d;
   logic [n-1:0] acc_q, acc_d;
   logic         carry_q, carry_d;
   logic [7:0]   op_count_q, op_count_d;
   logic [2:0]   mode_q, mode_d;
   logic [n-1:0] opnd_q, opnd_d;
   logic         load_q, load_d;
   // Copies of the ALU drive taken when EXEC ends, so the ALU inputs keep
   // their last values in every other state.
   logic [n-1:0] hold_a_q, hold_a_d;
   logic [n-1:0] hold_b_q, hold_b_d;
   logic [2:0]   hold_mode_q, hold_mode_d;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         op_count_q  <= '0;
         mode_q      <= '0;
         opnd_q      <= '0;
         load_q      <= 1'b0;
         hold_a_q    <= '0;
         hold_b_q    <= '0;
         hold_mode_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         op_count_q  <= op_count_d;
         mode_q      <= mode_d;
         opnd_q      <= opnd_d;
         load_q      <= load_d;
         hold_a_q    <= hold_a_d;
         hold_b_q    <= hold_b_d;
         hold_mode_q <= hold_mode_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      op_count_d  = op_count_q;
      mode_d      = mode_q;
      opnd_d      = opnd_q;
      load_d      = load_q;
      hold_a_d    = hold_a_q;
      hold_b_d    = hold_b_q;
      hold_mode_d = hold_mode_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               mode_d = cmd_mode;
               opnd_d = cmd_opnd;
               load_d = cmd_load;
               if (cmd_load) begin
                  acc_d   = cmd_opnd;
                  carry_d = 1'b0;
                  state_d = RESP;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            // Latch what the ALU saw this cycle so its inputs stay put afterwards.
            hold_a_d    = acc_q;
            hold_b_d    = opnd_q;
            hold_mode_d = mode_q;
            if (!load_q) begin
               acc_d   = alu_result;
               carry_d = alu_carry_borrow;
               if (op_count_q != 8'hFF) begin
                  op_count_d = op_count_q + 8'd1;
               end
            end
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      cmd_ready  = (state_q == IDLE);
      rsp_valid  = (state_q == RESP);
      rsp_result = acc_q;
      rsp_carry  = carry_q;
      rsp_zero   = (acc_q == '0);
      op_count   = op_count_q;
      if (state_q == EXEC) begin
         alu_a    = acc_q;
         alu_b    = opnd_q;
         alu_mode = mode_q;
      end else begin
         alu_a    = hold_a_q;
         alu_b    = hold_b_q;
         alu_mode = hold_mode_q;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_load;
   logic [2:0] cmd_mode;
   logic [3:0] cmd_opnd;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_mode;
   logic [3:0] alu_result;
   logic       alu_carry_borrow;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_result;
   logic       rsp_carry;
   logic       rsp_zero;
   logic [7:0] op_count;

   int n_checks = 0;
   int n_fail   = 0;

   alu_op_sequencer #(.n(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_load         (cmd_load),
      .cmd_mode         (cmd_mode),
      .cmd_opnd         (cmd_opnd),
      .alu_a            (alu_a),
      .alu_b            (alu_b),
      .alu_mode         (alu_mode),
      .alu_result       (alu_result),
      .alu_carry_borrow (alu_carry_borrow),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_result       (rsp_result),
      .rsp_carry        (rsp_carry),
      .rsp_zero         (rsp_zero),
      .op_count         (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream ALU: 000 add, 001 subtract (carry = borrow), 010 and,
   // 011 or, 100 xor, others pass A.
   always_comb begin
      logic [4:0] wide;
      wide             = 5'd0;
      alu_result       = alu_a;
      alu_carry_borrow = 1'b0;
      case (alu_mode)
         3'b000: begin
            wide             = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result       = wide[3:0];
            alu_carry_borrow = wide[4];
         end
         3'b001: begin
            alu_result       = alu_a - alu_b;
            alu_carry_borrow = (alu_a < alu_b);
         end
         3'b010: alu_result = alu_a & alu_b;
         3'b011: alu_result = alu_a | alu_b;
         3'b100: alu_result = alu_a ^ alu_b;
         default: alu_result = alu_a;
      endcase
   end

   // Offer a command, wait (bounded) for cmd_ready, return after the
   // acceptance edge (+1) with ok telling whether it was accepted.
   task automatic send(input logic ld, input logic [2:0] md, input logic [3:0] op, output bit ok);
      cmd_valid = 1'b1;
      cmd_load  = ld;
      cmd_mode  = md;
      cmd_opnd  = op;
      for (int i = 0; i < 20 && !cmd_ready; i++) begin
         @(posedge clk); #1;
      end
      ok = cmd_ready;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (cmd_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      n_checks++; if (rsp_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_result !== 4'h0)    begin n_fail++; $display("FAIL reset_result: got %h want 0", rsp_result); end
      n_checks++; if (rsp_carry !== 1'b0)     begin n_fail++; $display("FAIL reset_carry: got %b want 0", rsp_carry); end
      n_checks++; if (rsp_zero !== 1'b1)      begin n_fail++; $display("FAIL reset_zero: got %b want 1", rsp_zero); end
      n_checks++; if (op_count !== 8'd0)      begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
      n_checks++; if ({alu_a, alu_b, alu_mode} !== 11'd0) begin n_fail++; $display("FAIL reset_alu_drive: got %h/%h/%h want 0/0/0", alu_a, alu_b, alu_mode); end
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      bit ok;
      send(1'b1, 3'b000, 4'b0101, ok);
      n_checks++; if (ok !== 1'b1)            begin n_fail++; $display("FAIL add_load_accept: got %b want 1", ok); end
      n_checks++; if (rsp_valid !== 1'b1)     begin n_fail++; $display("FAIL add_load_latency: got %b want 1", rsp_valid); end
      n_checks++; if (rsp_result !== 4'b0101) begin n_fail++; $display("FAIL add_load_value: got %b want 0101", rsp_result); end
      ack();
      send(1'b0, 3'b000, 4'b0011, ok);
      n_checks++; if (ok !== 1'b1)            begin n_fail++; $display("FAIL add_accept: got %b want 1", ok); end
      n_checks++; if (rsp_valid !== 1'b0)     begin n_fail++; $display("FAIL add_exec_valid: got %b want 0", rsp_valid); end
      n_checks++; if (cmd_ready !== 1'b0)     begin n_fail++; $display("FAIL add_exec_ready: got %b want 0", cmd_ready); end
      n_checks++; if ({alu_a, alu_b, alu_mode} !== {4'b0101, 4'b0011, 3'b000}) begin n_fail++; $display("FAIL add_exec_drive: got %b/%b/%b want 0101/0011/000", alu_a, alu_b, alu_mode); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1)     begin n_fail++; $display("FAIL add_latency: got %b want 1", rsp_valid); end
      n_checks++; if (rsp_result !== 4'b1000) begin n_fail++; $display("FAIL add_result: got %b want 1000", rsp_result); end
      n_checks++; if (rsp_carry !== 1'b0)     begin n_fail++; $display("FAIL add_carry: got %b want 0", rsp_carry); end
      n_checks++; if (rsp_zero !== 1'b0)      begin n_fail++; $display("FAIL add_zero: got %b want 0", rsp_zero); end
      n_checks++; if (op_count !== 8'd1)      begin n_fail++; $display("FAIL add_op_count: got %0d want 1", op_count); end
      n_checks++; if ({alu_a, alu_b, alu_mode} !== {4'b0101, 4'b0011, 3'b000}) begin n_fail++; $display("FAIL add_resp_hold: got %b/%b/%b want 0101/0011/000", alu_a, alu_b, alu_mode); end
      ack();
      n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_after_ack: got ready %b valid %b want 1 0", cmd_ready, rsp_valid); end
   endtask

   task automatic test_carry();
      bit ok;
      send(1'b1, 3'b000, 4'b1111, ok);
      ack();
      send(1'b0, 3'b000, 4'b0001, ok);
      @(posedge clk); #1;
      n_checks++; if (rsp_result !== 4'b0000) begin n_fail++; $display("FAIL carry_result: got %b want 0000", rsp_result); end
      n_checks++; if (rsp_carry !== 1'b1)     begin n_fail++; $display("FAIL carry_flag: got %b want 1", rsp_carry); end
      n_checks++; if (rsp_zero !== 1'b1)      begin n_fail++; $display("FAIL carry_zero: got %b want 1", rsp_zero); end
      n_checks++; if (op_count !== 8'd2)      begin n_fail++; $display("FAIL carry_op_count: got %0d want 2", op_count); end
      ack();
   endtask

   task automatic test_sub();
      bit ok;
      send(1'b1, 3'b000, 4'b0000, ok);
      n_checks++; if (rsp_carry !== 1'b0)     begin n_fail++; $display("FAIL sub_load_clears_carry: got %b want 0", rsp_carry); end
      n_checks++; if (rsp_zero !== 1'b1)      begin n_fail++; $display("FAIL sub_load_zero: got %b want 1", rsp_zero); end
      n_checks++; if (op_count !== 8'd2)      begin n_fail++; $display("FAIL sub_load_op_count: got %0d want 2", op_count); end
      ack();
      send(1'b0, 3'b001, 4'b0001, ok);
      n_checks++; if (alu_mode !== 3'b001)    begin n_fail++; $display("FAIL sub_exec_mode: got %b want 001", alu_mode); end
      @(posedge clk); #1;
      n_checks++; if (rsp_result !== 4'b1111) begin n_fail++; $display("FAIL sub_result: got %b want 1111", rsp_result); end
      n_checks++; if (rsp_carry !== 1'b1)     begin n_fail++; $display("FAIL sub_borrow: got %b want 1", rsp_carry); end
      n_checks++; if (rsp_zero !== 1'b0)      begin n_fail++; $display("FAIL sub_zero: got %b want 0", rsp_zero); end
      ack();
   endtask

   task automatic test_mode_passthrough();
      bit ok;
      send(1'b0, 3'b100, 4'b0101, ok);
      n_checks++; if (alu_mode !== 3'b100)    begin n_fail++; $display("FAIL mode4_exec_mode: got %b want 100", alu_mode); end
      @(posedge clk); #1;
      n_checks++; if (rsp_result !== 4'b1010 || rsp_carry !== 1'b0) begin n_fail++; $display("FAIL mode4_result: got %b c%b want 1010 c0", rsp_result, rsp_carry); end
      ack();
      send(1'b0, 3'b111, 4'b0011, ok);
      n_checks++; if (alu_mode !== 3'b111)    begin n_fail++; $display("FAIL mode7_exec_mode: got %b want 111", alu_mode); end
      @(posedge clk); #1;
      n_checks++; if (rsp_result !== 4'b1010) begin n_fail++; $display("FAIL mode7_result: got %b want 1010", rsp_result); end
      n_checks++; if (op_count !== 8'd5)      begin n_fail++; $display("FAIL mode_op_count: got %0d want 5", op_count); end
      ack();
   endtask

   task automatic test_backpressure();
      bit ok;
      send(1'b0, 3'b000, 4'b0011, ok);
      @(posedge clk); #1;
      // Next command offered while the response is stalled.
      cmd_valid = 1'b1;
      cmd_load  = 1'b1;
      cmd_mode  = 3'b000;
      cmd_opnd  = 4'b1010;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 4'b1101 || rsp_carry !== 1'b0)
            begin n_fail++; $display("FAIL bp_stall[%0d]: got ready %b valid %b res %b c%b want 0 1 1101 c0", i, cmd_ready, rsp_valid, rsp_result, rsp_carry); end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready %b valid %b want 1 0", cmd_ready, rsp_valid); end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'b1010) begin n_fail++; $display("FAIL bp_waiting_cmd: got valid %b res %b want 1 1010", rsp_valid, rsp_result); end
      n_checks++; if (op_count !== 8'd6)      begin n_fail++; $display("FAIL bp_op_count: got %0d want 6", op_count); end
      ack();
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (op_count !== 8'd6 || rsp_valid !== 1'b0 || rsp_result !== 4'b1010) begin n_fail++; $display("FAIL no_reexec: got cnt %0d valid %b res %b want 6 0 1010", op_count, rsp_valid, rsp_result); end
   endtask

   task automatic test_reset_in_exec();
      bit ok;
      send(1'b1, 3'b000, 4'b0011, ok);
      ack();
      send(1'b0, 3'b000, 4'b0001, ok);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_checks++; if (rsp_result !== 4'h0 || rsp_zero !== 1'b1) begin n_fail++; $display("FAIL rst_exec_acc: got %b z%b want 0000 z1", rsp_result, rsp_zero); end
      n_checks++; if (rsp_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_exec_valid: got %b want 0", rsp_valid); end
      n_checks++; if (op_count !== 8'd0)      begin n_fail++; $display("FAIL rst_exec_op_count: got %0d want 0", op_count); end
      n_checks++; if (cmd_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_exec_ready: got %b want 1", cmd_ready); end
      n_checks++; if ({alu_a, alu_b, alu_mode} !== 11'd0) begin n_fail++; $display("FAIL rst_exec_alu: got %h/%h/%h want 0/0/0", alu_a, alu_b, alu_mode); end
      // A reset pulse that never covers a rising edge must be ignored.
      send(1'b1, 3'b000, 4'b0110, ok);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'b0110) begin n_fail++; $display("FAIL rst_glitch: got valid %b res %b want 1 0110", rsp_valid, rsp_result); end
      ack();
   endtask

   task automatic test_saturation();
      bit ok;
      int bad;
      bad = 0;
      for (int i = 0; i < 260; i++) begin
         send(1'b0, 3'b000, 4'b0001, ok);
         @(posedge clk); #1;
         if (!ok || rsp_valid !== 1'b1) bad++;
         ack();
         if (i == 254) begin
            n_checks++; if (op_count !== 8'd255) begin n_fail++; $display("FAIL sat_reach_255: got %0d want 255", op_count); end
         end
      end
      n_checks++; if (bad !== 0)             begin n_fail++; $display("FAIL sat_handshakes: got %0d bad want 0", bad); end
      n_checks++; if (op_count !== 8'd255)   begin n_fail++; $display("FAIL sat_hold: got %0d want 255", op_count); end
      // acc started at 0110 and saw 260 increments: (6 + 260) mod 16 = 10
      n_checks++; if (rsp_result !== 4'b1010) begin n_fail++; $display("FAIL sat_acc: got %b want 1010", rsp_result); end
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_load  = 1'b0;
      cmd_mode  = 3'b000;
      cmd_opnd  = 4'h0;
      rsp_ready = 1'b0;
      test_reset();
      test_add();
      test_carry();
      test_sub();
      test_mode_passthrough();
      test_backpressure();
      test_reset_in_exec();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
